inst_loader: RTL
================

# inst_loader

Boot-time program loader that writes the instruction memory from a byte stream. It receives a framed program image over a valid/ready byte interface and assembles big-endian 16-bit instruction words. It drives the instruction memory's write port at even byte addresses starting at 0x0000. While loading, it holds the CPU core in reset so the fetch side never reads a partially written image.

## Interface
Parameters:
- MAX_WORDS, 128: capacity in 16-bit words. Valid word addresses are 0x00..(2*MAX_WORDS-2).

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse that begins a load; honoured only in IDLE
- in_valid  in  1  byte source has data
- in_data  in  8  byte payload
- in_ready  out  1  loader accepts a byte this cycle
- wr_en  out  1  instruction memory write strobe, one cycle per word
- wr_addr  out  16  byte address of the word; always even
- wr_data  out  16  instruction word, {first byte, second byte}
- cpu_hold  out  1  holds the core in reset while high
- done  out  1  last load completed with a good checksum; sticky
- err  out  1  last load failed (length or checksum); sticky
- words_loaded  out  16  words written in the current or last load

## Operation
- Frame format: LEN_HI, LEN_LO, then N words each sent as HI byte then LO byte, then CHK. N = {LEN_HI, LEN_LO}.
- CHK is the XOR of every data byte. Length bytes are excluded from the checksum.
- A byte transfers on a cycle where in_valid && in_ready are both high.
- States and transitions:
  - IDLE: in_ready=0. On start, go to LEN_HI, set cpu_hold=1, clear done, err, words_loaded and the checksum accumulator.
  - LEN_HI → LEN_LO on a transfer.
  - LEN_LO: on a transfer, latch N.
    - If N > MAX_WORDS, go to ERR.
    - If N == 0, go to CHK.
    - Otherwise go to DATA_HI.
  - DATA_HI → DATA_LO on a transfer; latch the HI byte.
  - DATA_LO: on a transfer, issue a write. Go to CHK if this was word N-1, else go to DATA_HI.
  - CHK: on a transfer, compare the byte with the accumulator.
    - Match: go to IDLE, set done=1, set cpu_hold=0.
    - Mismatch: go to ERR.
  - ERR: set err=1, keep cpu_hold=1, in_ready=0. Go to IDLE on the next cycle, with err and cpu_hold still held there.
- cpu_hold clears only on a successful load. A later start re-asserts it.
- start is ignored outside IDLE.
- Word k is written to wr_addr = 2*k, for k = 0..N-1. The address is 16-bit with no wrap; the bound is enforced by the length check.
- The checksum accumulates only on accepted data bytes. Stalls (in_valid=0) do not change any state.

## Timing
- Reset values: state IDLE, in_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_hold=0, done=0, err=0, words_loaded=0.
- in_ready is high in LEN_HI, LEN_LO, DATA_HI, DATA_LO and CHK; there is no other backpressure. Sustained throughput is one byte per cycle.
- Write latency: a DATA_LO transfer on cycle t gives wr_en=1 on cycle t+1 with registered wr_addr and wr_data. wr_en is high for exactly one cycle per word. words_loaded increments on the same cycle t+1.
- Back-to-back words therefore produce wr_en every second cycle at full input rate.
- done, err and cpu_hold update on the cycle after the CHK transfer.
- ERR lasts exactly one cycle.
- Reset asserted mid-load returns all outputs to their reset values on the next edge. Memory contents are then undefined for partially written words, and cpu_hold=0 after reset. System integration must keep rst_n low until a new start is issued if the image is not trusted.
- start and rst_n low in the same cycle: reset wins.

## Structure
- Shared package loader_pkg holds:
  - the state enum (IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHK, ERR)
  - the byte width constant (8)
  - the word width constant (16)
- Single module with no sub-modules; the byte assembly and checksum are too small to split out.

## Test plan
- Load N=2, bytes 00 02 | 01 2F | 01 2E | CHK=01: writes (0x0000, 0x012F) then (0x0002, 0x012E); done=1, err=0, cpu_hold=0, words_loaded=2.
- Same frame with in_valid toggling every other cycle: identical writes and final state; each wr_en pulse is one cycle wide.
- Bad checksum (00 01 | 88 09 | CHK=00, correct is 0x81): one write at 0x0000 of 0x8809; err=1, done=0, cpu_hold stays 1.
- Length overflow, MAX_WORDS=128, header 00 81: no wr_en; err=1 one cycle after LEN_LO is accepted, and in_ready drops.
- N=0 (00 00 | CHK=00): no writes; done=1, words_loaded=0.
- Reset during DATA_LO of word 3, then start and a valid N=1 frame: all outputs read reset values after the reset edge; the new load writes address 0x0000 and finishes with done=1.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types and widths for the boot-time instruction loader.
package loader_pkg;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEN_HI  = 3'd1,
        ST_LEN_LO  = 3'd2,
        ST_DATA_HI = 3'd3,
        ST_DATA_LO = 3'd4,
        ST_CHK     = 3'd5,
        ST_ERR     = 3'd6
    } state_e;

endpackage

// File: rtl/inst_loader.sv
// Loads a framed, XOR-checksummed byte stream into instruction memory as
// big-endian 16-bit words, holding the core in reset until a good image lands.
module inst_loader
    import loader_pkg::*;
#(
    parameter int MAX_WORDS = 128
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                in_valid,
    input  logic [BYTE_W-1:0]   in_data,
    output logic                in_ready,
    output logic                wr_en,
    output logic [WORD_W-1:0]   wr_addr,
    output logic [WORD_W-1:0]   wr_data,
    output logic                cpu_hold,
    output logic                done,
    output logic                err,
    output logic [WORD_W-1:0]   words_loaded
);

    state_e              state_q, state_d;
    logic [WORD_W-1:0]   len_q, len_d;
    logic [BYTE_W-1:0]   hi_q, hi_d;
    logic [BYTE_W-1:0]   chk_q, chk_d;
    logic                wr_en_q, wr_en_d;
    logic [WORD_W-1:0]   wr_addr_q, wr_addr_d;
    logic [WORD_W-1:0]   wr_data_q, wr_data_d;
    logic                hold_q, hold_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [WORD_W-1:0]   words_q, words_d;

    logic                xfer;
    logic [WORD_W-1:0]   len_full;

    assign in_ready = (state_q == ST_LEN_HI) || (state_q == ST_LEN_LO) ||
                      (state_q == ST_DATA_HI) || (state_q == ST_DATA_LO) ||
                      (state_q == ST_CHK);
    assign xfer     = in_valid && in_ready;
    assign len_full = {len_q[WORD_W-1:BYTE_W], in_data};

    always_comb begin
        // NOTE: every next-state signal gets a default first so no latch is inferred.
        state_d   = state_q;
        len_d     = len_q;
        hi_d      = hi_q;
        chk_d     = chk_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        hold_d    = hold_q;
        done_d    = done_q;
        err_d     = err_q;
        words_d   = words_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LEN_HI;
                    hold_d  = 1'b1;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    words_d = '0;
                    chk_d   = '0;
                end
            end
            ST_LEN_HI: begin
                if (xfer) begin
                    len_d   = {in_data, len_q[BYTE_W-1:0]};
                    state_d = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (xfer) begin
                    len_d = len_full;
                    if (len_full > WORD_W'(MAX_WORDS)) begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                    end else if (len_full == '0) begin
                        state_d = ST_CHK;
                    end else begin
                        state_d = ST_DATA_HI;
                    end
                end
            end
            ST_DATA_HI: begin
                if (xfer) begin
                    hi_d    = in_data;
                    chk_d   = chk_q ^ in_data;
                    state_d = ST_DATA_LO;
                end
            end
            ST_DATA_LO: begin
                if (xfer) begin
                    // words_q still counts only completed words, so it is this word's index.
                    chk_d     = chk_q ^ in_data;
                    wr_en_d   = 1'b1;
                    wr_addr_d = {words_q[WORD_W-2:0], 1'b0};
                    wr_data_d = {hi_q, in_data};
                    words_d   = words_q + 1'b1;
                    state_d   = (words_q == len_q - 1'b1) ? ST_CHK : ST_DATA_HI;
                end
            end
            ST_CHK: begin
                if (xfer) begin
                    if (in_data == chk_q) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                    end else begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                    end
                end
            end
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            len_q     <= '0;
            hi_q      <= '0;
            chk_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            hold_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            words_q   <= '0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            hi_q      <= hi_d;
            chk_q     <= chk_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            hold_q    <= hold_d;
            done_q    <= done_d;
            err_q     <= err_d;
            words_q   <= words_d;
        end
    end

    assign wr_en        = wr_en_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign cpu_hold     = hold_q;
    assign done         = done_q;
    assign err          = err_q;
    assign words_loaded = words_q;

endmodule
